// File: rtl/cache_2way.sv
// cache_2way: two-way set-associative, write-through data cache between the
// core memory stage and data memory. One 32-bit word per line, one LRU bit
// per set naming the victim way. Loads that hit return data combinationally;
// load misses fill from memory (FILL); every store writes through (WRITE)
// and retires in a one-cycle DONE state.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cacheEn, wen       access qualifier, store(1)/load(0)
//   DataWidth          000 W, 001 H, 010 B, 101 HU, 110 BU, others = word
//   addr, wdata        byte address, right-aligned store data
//   rdata, stall, Hit  load result, core hold, lookup hit
//   mem_req/we/addr/wdata/width, mem_ready, mem_rdata   memory handshake
//   hit_count, miss_count  statistics
//
// Optional feature: define CACHE_STATS_EN to build the hit/miss counters;
// otherwise both count ports are tied to zero.
module cache_2way #(
  parameter int SET_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cacheEn,
  input  logic        wen,
  input  logic [2:0]  DataWidth,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        Hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
  state_t state_q;

  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [31:0]          data_q [2][SETS];

  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [2:0]  mem_width_q;

  function automatic logic is_byte(input logic [2:0] w);
    return (w == 3'b010) || (w == 3'b110);
  endfunction
  function automatic logic is_half(input logic [2:0] w);
    return (w == 3'b001) || (w == 3'b101);
  endfunction

  // Lane extract + sign/zero extension for loads.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0] off,
                                          input logic [2:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    if (is_byte(w))      return (w == 3'b010) ? {{24{b[7]}}, b} : {24'b0, b};
    else if (is_half(w)) return (w == 3'b001) ? {{16{h[15]}}, h} : {16'b0, h};
    else                 return word;
  endfunction

  // Store merge: only the written lanes replace the old line word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [1:0]  off,
                                        input logic [2:0]  w);
    logic [31:0] m, v;
    if (is_byte(w)) begin
      m = 32'h0000_00FF << {off, 3'b000};
      v = {24'b0, d[7:0]} << {off, 3'b000};
    end else if (is_half(w)) begin
      m = 32'h0000_FFFF << {off[1], 4'b0000};
      v = {16'b0, d[15:0]} << {off[1], 4'b0000};
    end else begin
      m = '1;
      v = d;
    end
    return (old & ~m) | (v & m);
  endfunction

  // Lookup on the live core address (IDLE decisions, Hit, rdata).
  logic [SET_BITS-1:0] idx_c;
  logic [TAG_W-1:0]    tag_c;
  logic [1:0]          hit_c;
  logic                match, way_c, ld_hit;
  assign idx_c = addr[SET_BITS+1:2];
  assign tag_c = addr[31:SET_BITS+2];
  always_comb begin
    hit_c = '0;
    for (int w = 0; w < 2; w++)
      hit_c[w] = valid_q[w][idx_c] && (tag_q[w][idx_c] == tag_c);
  end
  assign match  = |hit_c;
  assign way_c  = !hit_c[0];
  assign ld_hit = (state_q == S_IDLE) && cacheEn && !wen && match;

  // Lookup on the latched request address (fill victim, store-hit merge).
  logic [SET_BITS-1:0] idx_l;
  logic [TAG_W-1:0]    tag_l;
  logic [1:0]          hit_l;
  logic                way_l, vict;
  assign idx_l = mem_addr_q[SET_BITS+1:2];
  assign tag_l = mem_addr_q[31:SET_BITS+2];
  always_comb begin
    hit_l = '0;
    for (int w = 0; w < 2; w++)
      hit_l[w] = valid_q[w][idx_l] && (tag_q[w][idx_l] == tag_l);
  end
  assign way_l = !hit_l[0];
  // Invalid way0 first, then invalid way1, else the LRU-named way.
  assign vict  = !valid_q[0][idx_l] ? 1'b0 :
                 !valid_q[1][idx_l] ? 1'b1 : lru_q[idx_l];

  assign Hit   = cacheEn && match;
  assign rdata = ld_hit ? extract(data_q[way_c][idx_c], addr[1:0], DataWidth) : 32'b0;
  always_comb begin
    case (state_q)
      S_IDLE:          stall = cacheEn && (wen || !match);
      S_FILL, S_WRITE: stall = 1'b1;
      default:         stall = 1'b0;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_width = mem_width_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      lru_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_hit) begin
            lru_q[idx_c] <= !way_c;
          end else if (cacheEn && !wen) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_width_q <= DataWidth;
            state_q     <= S_FILL;
          end else if (cacheEn) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr;
            mem_wdata_q <= wdata;
            mem_width_q <= DataWidth;
            state_q     <= S_WRITE;
          end
        end
        S_FILL: if (mem_ready) begin
          valid_q[vict][idx_l] <= 1'b1;
          lru_q[idx_l]         <= !vict;
          mem_req_q            <= 1'b0;
          state_q              <= S_IDLE;
        end
        S_WRITE: if (mem_ready) begin
          if (|hit_l) lru_q[idx_l] <= !way_l;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line payload needs no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && mem_ready) begin
      tag_q[vict][idx_l]  <= tag_l;
      data_q[vict][idx_l] <= mem_rdata;
    end else if (state_q == S_WRITE && mem_ready && |hit_l) begin
      data_q[way_l][idx_l] <= merge(data_q[way_l][idx_l], mem_wdata_q,
                                    mem_addr_q[1:0], mem_width_q);
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ld_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == S_IDLE && cacheEn && !wen && !match)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'b0;
  assign miss_count = 32'b0;
`endif
endmodule

// File: doc/cache_2way.md
# cache_2way

Parametrised two-way set-associative, write-through data cache that sits between the core's memory stage and data memory. Successor to the single-way direct-mapped cache: it adds LRU replacement, byte-lane handling of `addr[1:0]` for sub-word accesses, a request/ready handshake to memory with a core stall output, and optional hit/miss counters.

## Interface
- `SET_BITS`, 3: index width. Sets = 2**SET_BITS. Tag = `addr[31:SET_BITS+2]`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cacheEn` in 1: the current instruction is a load or store.
- `wen` in 1: store when 1, load when 0. Qualified by `cacheEn`.
- `DataWidth` in 3: 000 word, 001 half, 010 byte, 101 half unsigned, 110 byte unsigned. Any other code is treated as word.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: load result, extended per `DataWidth`.
- `stall` out 1: the core must hold the instruction.
- `Hit` out 1: lookup hit. Combinational, valid in IDLE.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 means write request.
- `mem_addr` out 32: `{addr[31:2],2'b00}` for fills; the full byte address for writes.
- `mem_wdata` out 32: store data, right-aligned.
- `mem_width` out 3: latched `DataWidth`.
- `mem_ready` in 1: memory completes the request this cycle.
- `mem_rdata` in 32: fill word, valid when `mem_ready`=1.
- `hit_count` out 32, `miss_count` out 32: statistics counters (see Configuration).

## Operation
- Storage per set:
  - 2 ways, each holding a valid bit, a tag and a 32-bit word.
  - 1 LRU bit that names the victim way.
- Hit: some valid way has a matching tag. `Hit = cacheEn && match`.
- Lane select uses `addr[1:0]`:
  - Byte accesses use lane `addr[1:0]`.
  - Half accesses use lane `addr[1]`; `addr[0]` is ignored.
  - Loads extract the lane, then sign- or zero-extend per `DataWidth`.
- States:
  - IDLE:
    - `stall = cacheEn && (wen || !match)`.
    - `rdata` = extended hit data on a load hit, else 0.
    - Load hit: no state change. The LRU bit is set to the other way.
    - Load miss: latch address and width, go to FILL.
    - Store (hit or miss): latch address, data and width, go to WRITE.
  - FILL:
    - `mem_req`=1, `mem_we`=0, `stall`=1.
    - On `mem_ready`: write `mem_rdata` into the victim way (invalid way0 first, then invalid way1, else the LRU way). Set valid, write the tag, flip LRU away from the filled way. Go to IDLE.
    - The load then hits in IDLE.
  - WRITE:
    - `mem_req`=1, `mem_we`=1, `stall`=1.
    - On `mem_ready` with a store hit: merge the written lanes into the matching way and update LRU.
    - On `mem_ready` with a store miss: no allocation, line state unchanged.
    - Go to DONE.
  - DONE:
    - `stall`=0 and no lookup action, so the core retires the store.
    - Next state IDLE.
- Request outputs come only from latched registers. They are stable while `mem_req`=1.
- Memory must accept requests held for any number of cycles.

## Timing
- Reset (async, immediate):
  - State IDLE; all valid and LRU bits 0; counters 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_width`=0.
  - `stall`, `Hit` and `rdata` are 0 while `cacheEn`=0.
- Load hit: 0-cycle latency (`rdata` combinational) and no stall.
- Load miss, `mem_ready` k cycles after FILL entry (k≥0): `stall` high for k+2 cycles. The line is written at the `mem_ready` edge.
- Store: `stall` high for k+2 cycles, then low for the DONE cycle.
- `mem_ready` is ignored in IDLE and DONE.
- Reset during FILL or WRITE:
  - The request is abandoned; `mem_req` drops immediately.
  - No line is written.
- Two fills to the same set with both ways valid alternate victims.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE load hit.
  - `miss_count` increments on each FILL entry.
  - Both are 32-bit, wrap modulo 2**32, and reset to 0.
- `CACHE_STATS_EN` undefined: both ports are tied to 0 and no counter registers exist.

## Test plan
- After reset, load word at 0x100 with `mem_ready` after 2 cycles and `mem_rdata`=0xDEADBEEF → `stall` high 4 cycles, then `rdata`=0xDEADBEEF and `Hit`=1. A reload of 0x100 gives 0 stall cycles.
- Fill 0x100 (0x11111111) and 0x120 (0x22222222), same set with SET_BITS=3. Reload 0x100, then fill 0x140 → 0x120 is evicted, 0x100 still hits, a load of 0x120 misses.
- Word 0x80FF7F01 cached at 0x200:
  - LB 0x200 → 0x00000001.
  - LB 0x203 → 0xFFFFFF80.
  - LBU 0x203 → 0x00000080.
  - LH 0x202 → 0xFFFF80FF.
  - LHU 0x200 → 0x00007F01.
- SB 0xAB to 0x201 on a hit → `mem_we`=1 with `mem_addr`=0x201 held until `mem_ready`, one DONE cycle with `stall`=0, then LW 0x200 → 0x80FFAB01. SW to an uncached 0x300 → a later LW 0x300 misses.
- Assert `rst` mid-FILL → `mem_req`=0 in the same cycle and the line stays invalid. With `CACHE_STATS_EN`, after 3 hits and 2 misses `hit_count`=3 and `miss_count`=2; reset clears both.
